// File: rtl/j17_pkg.sv
// j17_pkg: shared definitions for the J17 fetch/decode front end.
//   - Opcode boundaries of the 5-bit opc field.
//   - pcControl and alucode code points.
//   - Fetch FSM state encoding.
//   - Packed bundle of the decoded control fields handed to the DP.
//   - Helper that flags opcodes with no defined meaning.
package j17_pkg;

    localparam logic [4:0] OPC_ALU_MAX = 5'd11;  // opc 0..11 are ALU ops, alucode = opc
    localparam logic [4:0] OPC_MOV     = 5'd12;
    localparam logic [4:0] OPC_BR_BASE = 5'd16;  // first branch/jump opcode
    localparam logic [4:0] OPC_BR_MAX  = 5'd22;  // last branch/jump opcode
    localparam logic [4:0] OPC_NOP     = 5'd23;

    // Branch opcodes map onto pcControl = opc - 15, i.e. 1..7.
    localparam logic [4:0] OPC_BR_OFFSET = 5'd15;

    localparam logic [2:0] PC_SEQ      = 3'd0;   // fall through to PC+1
    localparam logic [2:0] PC_BR_FIRST = 3'd1;
    localparam logic [2:0] PC_BR_LAST  = 3'd7;

    localparam logic [4:0] ALU_NONE = 5'd0;
    localparam logic [4:0] ALU_ADD  = 5'd1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_HALT  = 3'd4
    } fd_state_t;

    typedef struct packed {
        logic [4:0]  alucode;
        logic [2:0]  op1;
        logic [20:0] op2;
        logic        im_control;
        logic        flag;
        logic        flag1;
        logic [2:0]  pc_control;
        logic        writecode;
        logic        regenable;
        logic [1:0]  ramenable;
        logic [1:0]  stack_select;
    } ctrl_t;

    // opc 13..15 and 24..31 have no defined meaning.
    function automatic logic opc_is_illegal(input logic [4:0] opc);
        return ((opc > OPC_MOV) && (opc < OPC_BR_BASE)) || (opc > OPC_NOP);
    endfunction

endpackage

// File: rtl/j17_decode.sv
// j17_decode: purely combinational instruction word -> DP control fields.
//   Word layout: [31:27] opc, [26] imControl, [25] flag, [24] flag1,
//                [23:21] op1, [20:0] op2.
//   Operand and flag bits pass straight through; opc selects alucode,
//   pcControl, writecode and regenable. NOP and illegal opcodes leave all
//   of those at zero, so an illegal opcode behaves exactly like a NOP.
// Ports:
//   word     in   32  fetched instruction word
//   illegal  out  1   opc is undefined (only with FD_ILLEGAL_TRAP_EN)
//   ctrl     out  ctrl_t  decoded control fields
// Build option: FD_ILLEGAL_TRAP_EN adds the illegal output.
module j17_decode
    import j17_pkg::*;
(
    input  logic [31:0] word,
`ifdef FD_ILLEGAL_TRAP_EN
    output logic        illegal,
`endif
    output ctrl_t       ctrl
);

    logic [4:0] opc;
    assign opc = word[31:27];

    always_comb begin
        ctrl              = '0;
        ctrl.im_control   = word[26];
        ctrl.flag         = word[25];
        ctrl.flag1        = word[24];
        ctrl.op1          = word[23:21];
        ctrl.op2          = word[20:0];
        ctrl.ramenable    = {word[24], word[25]};
        ctrl.stack_select = 2'b00;
        ctrl.pc_control   = PC_SEQ;
        ctrl.alucode      = ALU_NONE;

        if (opc <= OPC_ALU_MAX) begin
            ctrl.alucode   = opc;
            ctrl.regenable = 1'b1;
        end else if (opc == OPC_MOV) begin
            ctrl.writecode = 1'b1;
            ctrl.regenable = 1'b1;
        end else if ((opc >= OPC_BR_BASE) && (opc <= OPC_BR_MAX)) begin
            ctrl.pc_control = 3'(opc - OPC_BR_OFFSET);
        end
    end

`ifdef FD_ILLEGAL_TRAP_EN
    assign illegal = opc_is_illegal(opc);
`endif

endmodule

// File: rtl/instr_fetch_decode.sv
// instr_fetch_decode: J17 front end. Fetches the word at the DP's PC over
// a req/ack handshake, decodes it and offers it to the DP over a
// valid/ready handshake, one instruction at a time.
//
//   state  | meaning
//   IDLE   | out of reset, starts fetching next cycle
//   REQ    | imem_req raised, address just sampled from pc_in
//   WAIT   | waiting for imem_ack, timeout counter running
//   ISSUE  | decoded fields valid, waiting for issue_ready
//   HALT   | illegal opcode trapped, parked until reset (trap build only)
//
// Ports:
//   clock, reset_n          clock, async active-low reset
//   pc_in                   current PC from DP
//   imem_req/addr/ack/data  instruction memory handshake
//   issue_valid/ready       issue handshake to DP
//   alucode..stackSelect    registered decoded control fields
//   retry_cnt               saturating count of ack timeouts
//   illegal                 high in HALT (only with FD_ILLEGAL_TRAP_EN)
// Build option: FD_ILLEGAL_TRAP_EN traps illegal opcodes instead of
// issuing them as NOPs.
module instr_fetch_decode
    import j17_pkg::*;
#(
    parameter int IADDR_W     = 10,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [31:0]        pc_in,
    output logic               imem_req,
    output logic [IADDR_W-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [31:0]        imem_data,
    output logic               issue_valid,
    input  logic               issue_ready,
    output logic [4:0]         alucode,
    output logic [2:0]         op1,
    output logic [20:0]        op2,
    output logic               imControl,
    output logic               flag,
    output logic               flag1,
    output logic [2:0]         pcControl,
    output logic               writecode,
    output logic               regenable,
    output logic [1:0]         ramenable,
    output logic [1:0]         stackSelect,
`ifdef FD_ILLEGAL_TRAP_EN
    output logic               illegal,
`endif
    output logic [7:0]         retry_cnt
);

    // Counter is loaded on entry to WAIT and times out at zero, giving
    // exactly ACK_TIMEOUT cycles in WAIT.
    localparam logic [7:0] TO_LOAD = 8'(ACK_TIMEOUT - 1);

    fd_state_t  state;
    logic [7:0] wait_cnt;
    ctrl_t      ctrl_q;
    ctrl_t      dec_ctrl;
    logic       trap_hit;

`ifdef FD_ILLEGAL_TRAP_EN
    logic dec_illegal;

    j17_decode u_decode (
        .word    (imem_data),
        .illegal (dec_illegal),
        .ctrl    (dec_ctrl)
    );

    assign trap_hit = dec_illegal;
    assign illegal  = (state == ST_HALT);
`else
    j17_decode u_decode (
        .word (imem_data),
        .ctrl (dec_ctrl)
    );

    assign trap_hit = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            issue_valid <= 1'b0;
            wait_cnt    <= '0;
            retry_cnt   <= '0;
            ctrl_q      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state     <= ST_REQ;
                    imem_req  <= 1'b1;
                    imem_addr <= pc_in[IADDR_W-1:0];
                end

                // An ack here is ignored: memory is only listened to in WAIT.
                ST_REQ: begin
                    state    <= ST_WAIT;
                    wait_cnt <= TO_LOAD;
                end

                // Ack is tested before the timeout so it wins a tie.
                ST_WAIT: begin
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        if (trap_hit) begin
                            state <= ST_HALT;
                        end else begin
                            state       <= ST_ISSUE;
                            issue_valid <= 1'b1;
                            ctrl_q      <= dec_ctrl;
                        end
                    end else if (wait_cnt == 8'd0) begin
                        state     <= ST_REQ;
                        imem_addr <= pc_in[IADDR_W-1:0];
                        if (retry_cnt != 8'hFF) begin
                            retry_cnt <= retry_cnt + 8'd1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end

                // DP has advanced its PC by the time it accepts, so re-sample.
                ST_ISSUE: begin
                    if (issue_ready) begin
                        state       <= ST_REQ;
                        issue_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        imem_addr   <= pc_in[IADDR_W-1:0];
                    end
                end

                ST_HALT: begin
                    state       <= ST_HALT;
                    imem_req    <= 1'b0;
                    issue_valid <= 1'b0;
                end

                default: begin
                    state       <= ST_IDLE;
                    imem_req    <= 1'b0;
                    issue_valid <= 1'b0;
                end
            endcase
        end
    end

    assign alucode     = ctrl_q.alucode;
    assign op1         = ctrl_q.op1;
    assign op2         = ctrl_q.op2;
    assign imControl   = ctrl_q.im_control;
    assign flag        = ctrl_q.flag;
    assign flag1       = ctrl_q.flag1;
    assign pcControl   = ctrl_q.pc_control;
    assign writecode   = ctrl_q.writecode;
    assign regenable   = ctrl_q.regenable;
    assign ramenable   = ctrl_q.ramenable;
    assign stackSelect = ctrl_q.stack_select;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// tb_instr_fetch_decode: directed vectors for instr_fetch_decode.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Build option: FD_ILLEGAL_TRAP_EN selects the trap expectations.
module tb_instr_fetch_decode;

    logic        clock;
    logic        reset_n;
    logic [31:0] pc_in;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        issue_valid;
    logic        issue_ready;
    logic [4:0]  alucode;
    logic [2:0]  op1;
    logic [20:0] op2;
    logic        imControl;
    logic        flag;
    logic        flag1;
    logic [2:0]  pcControl;
    logic        writecode;
    logic        regenable;
    logic [1:0]  ramenable;
    logic [1:0]  stackSelect;
    logic [7:0]  retry_cnt;
`ifdef FD_ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    int n_vec = 0;
    int n_bad = 0;

    localparam logic [31:0] W_ADD  = 32'h0820_0003;
    localparam logic [31:0] W_BR   = {5'd17, 1'b1, 2'b00, 3'd2, 21'h1F_FFFF};
    localparam logic [31:0] W_MOV  = {5'd12, 1'b0, 1'b1, 1'b1, 3'd7, 21'h0_0055};
    localparam logic [31:0] W_ALU5 = {5'd5, 1'b0, 1'b0, 1'b0, 3'd3, 21'd100};
    localparam logic [31:0] W_ILL  = {5'd30, 1'b0, 1'b0, 1'b0, 3'd0, 21'd0};

    instr_fetch_decode #(.IADDR_W(10), .ACK_TIMEOUT(15)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .pc_in       (pc_in),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .alucode     (alucode),
        .op1         (op1),
        .op2         (op2),
        .imControl   (imControl),
        .flag        (flag),
        .flag1       (flag1),
        .pcControl   (pcControl),
        .writecode   (writecode),
        .regenable   (regenable),
        .ramenable   (ramenable),
        .stackSelect (stackSelect),
`ifdef FD_ILLEGAL_TRAP_EN
        .illegal     (illegal),
`endif
        .retry_cnt   (retry_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n     = 1'b0;
        pc_in       = 32'd5;
        imem_ack    = 1'b0;
        imem_data   = 32'd0;
        issue_ready = 1'b0;
        step();
        step();

        // reset state
        chk("rst_req",   32'(imem_req),    32'd0);
        chk("rst_valid", 32'(issue_valid), 32'd0);
        chk("rst_addr",  32'(imem_addr),   32'd0);
        chk("rst_alu",   32'(alucode),     32'd0);
        chk("rst_reg",   32'(regenable),   32'd0);
        chk("rst_retry", 32'(retry_cnt),   32'd0);

        // 1: ADD fetch, ack on second WAIT cycle
        reset_n = 1'b1;
        step();                                  // IDLE -> REQ
        chk("t1_req",   32'(imem_req),    32'd1);
        chk("t1_addr",  32'(imem_addr),   32'd5);
        chk("t1_valid", 32'(issue_valid), 32'd0);
        step();                                  // REQ -> WAIT
        chk("t1_req_wait", 32'(imem_req), 32'd1);
        step();                                  // WAIT, no ack
        imem_ack  = 1'b1;
        imem_data = W_ADD;
        chk("t1_pre_valid", 32'(issue_valid), 32'd0);
        step();                                  // ack -> ISSUE
        imem_ack = 1'b0;
        chk("t1_valid", 32'(issue_valid), 32'd1);
        chk("t1_alu",   32'(alucode),     32'd1);
        chk("t1_op1",   32'(op1),         32'd1);
        chk("t1_op2",   32'(op2),         32'd3);
        chk("t1_reg",   32'(regenable),   32'd1);
        chk("t1_pc",    32'(pcControl),   32'd0);
        chk("t1_wr",    32'(writecode),   32'd0);
        chk("t1_req_drop", 32'(imem_req), 32'd0);

        // 4: DP stalls for 10 cycles
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t4_valid", 32'(issue_valid), 32'd1);
            chk("t4_alu",   32'(alucode),     32'd1);
            chk("t4_op2",   32'(op2),         32'd3);
            chk("t4_req",   32'(imem_req),    32'd0);
        end
        pc_in       = 32'd6;
        issue_ready = 1'b1;
        step();                                  // ISSUE -> REQ
        chk("t4_next_req",   32'(imem_req),    32'd1);
        chk("t4_next_addr",  32'(imem_addr),   32'd6);
        chk("t4_next_valid", 32'(issue_valid), 32'd0);

        // ack in REQ and ready with no valid are both ignored
        imem_ack  = 1'b1;
        imem_data = W_BR;
        step();                                  // REQ -> WAIT regardless
        chk("ack_in_req_valid", 32'(issue_valid), 32'd0);
        chk("ack_in_req_req",   32'(imem_req),    32'd1);
        step();                                  // ack in WAIT -> ISSUE
        imem_ack = 1'b0;

        // 2: branch word
        chk("t2_valid", 32'(issue_valid), 32'd1);
        chk("t2_pc",    32'(pcControl),   32'd2);
        chk("t2_imc",   32'(imControl),   32'd1);
        chk("t2_op2",   32'(op2),         32'h1F_FFFF);
        chk("t2_op1",   32'(op1),         32'd2);
        chk("t2_reg",   32'(regenable),   32'd0);
        chk("t2_alu",   32'(alucode),     32'd0);
        chk("t2_ram",   32'(ramenable),   32'd0);

        // MOV with both flags set; ready already high accepts at once
        pc_in = 32'd7;
        step();                                  // ISSUE -> REQ
        issue_ready = 1'b0;
        chk("mov_addr",  32'(imem_addr),   32'd7);
        chk("mov_pre_v", 32'(issue_valid), 32'd0);
        step();                                  // WAIT
        imem_ack  = 1'b1;
        imem_data = W_MOV;
        step();
        imem_ack = 1'b0;
        chk("mov_wr",    32'(writecode),   32'd1);
        chk("mov_reg",   32'(regenable),   32'd1);
        chk("mov_ram",   32'(ramenable),   32'd3);
        chk("mov_flag",  32'(flag),        32'd1);
        chk("mov_flag1", 32'(flag1),       32'd1);
        chk("mov_op1",   32'(op1),         32'd7);
        chk("mov_alu",   32'(alucode),     32'd0);
        chk("mov_stk",   32'(stackSelect), 32'd0);

        // 3: ack timeout, then ack on the exact timeout cycle
        pc_in       = 32'd9;
        issue_ready = 1'b1;
        step();                                  // -> REQ
        issue_ready = 1'b0;
        chk("t3_addr", 32'(imem_addr), 32'd9);
        step();                                  // -> WAIT
        for (int i = 0; i < 14; i++) begin
            step();
            chk("t3_wait_req",   32'(imem_req),  32'd1);
            chk("t3_wait_retry", 32'(retry_cnt), 32'd0);
        end
        pc_in = 32'd10;
        step();                                  // 15th WAIT cycle ends -> REQ
        chk("t3_retry", 32'(retry_cnt), 32'd1);
        chk("t3_req",   32'(imem_req),  32'd1);
        chk("t3_addr2", 32'(imem_addr), 32'd10);
        step();                                  // -> WAIT
        for (int i = 0; i < 14; i++) step();
        imem_ack  = 1'b1;
        imem_data = W_ALU5;
        step();                                  // ack ties with timeout
        imem_ack = 1'b0;
        chk("t3_tie_valid", 32'(issue_valid), 32'd1);
        chk("t3_tie_retry", 32'(retry_cnt),   32'd1);
        chk("t3_tie_alu",   32'(alucode),     32'd5);
        chk("t3_tie_req",   32'(imem_req),    32'd0);

        // 5: reset pulsed mid-WAIT
        pc_in       = 32'd11;
        issue_ready = 1'b1;
        step();                                  // -> REQ
        issue_ready = 1'b0;
        step();                                  // -> WAIT
        step();                                  // WAIT
        reset_n = 1'b0;
        #1;
        chk("t5_req",   32'(imem_req),    32'd0);
        chk("t5_valid", 32'(issue_valid), 32'd0);
        chk("t5_addr",  32'(imem_addr),   32'd0);
        chk("t5_alu",   32'(alucode),     32'd0);
        chk("t5_op2",   32'(op2),         32'd0);
        chk("t5_retry", 32'(retry_cnt),   32'd0);
        chk("t5_ram",   32'(ramenable),   32'd0);
        imem_ack  = 1'b1;
        imem_data = W_ADD;
        step();
        chk("t5_late_ack", 32'(issue_valid), 32'd0);
        reset_n = 1'b1;
        step();                                  // IDLE -> REQ, ack ignored
        chk("t5_restart_valid", 32'(issue_valid), 32'd0);
        chk("t5_restart_req",   32'(imem_req),    32'd1);
        chk("t5_restart_addr",  32'(imem_addr),   32'd11);
        imem_ack = 1'b0;
        step();                                  // -> WAIT
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        chk("t5_reissue_valid", 32'(issue_valid), 32'd1);
        chk("t5_reissue_alu",   32'(alucode),     32'd1);

        // 6: illegal opcode 30
        issue_ready = 1'b1;
        step();                                  // -> REQ
        issue_ready = 1'b0;
        step();                                  // -> WAIT
        imem_ack  = 1'b1;
        imem_data = W_ILL;
        step();
        imem_ack = 1'b0;
`ifdef FD_ILLEGAL_TRAP_EN
        chk("t6_illegal", 32'(illegal),     32'd1);
        chk("t6_valid",   32'(issue_valid), 32'd0);
        chk("t6_req",     32'(imem_req),    32'd0);
        issue_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t6_halt_req", 32'(imem_req), 32'd0);
            chk("t6_halt_ill", 32'(illegal),  32'd1);
        end
        issue_ready = 1'b0;
`else
        chk("t6_valid", 32'(issue_valid), 32'd1);
        chk("t6_reg",   32'(regenable),   32'd0);
        chk("t6_pc",    32'(pcControl),   32'd0);
        chk("t6_alu",   32'(alucode),     32'd0);
        chk("t6_wr",    32'(writecode),   32'd0);
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;
        chk("t6_next_req", 32'(imem_req), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
